// File: rtl/video_timing_pkg.sv
// Shared definitions for the video timing generator.
//   axis_state_t : phase of one timing axis (active, front porch, sync, back porch)
//   CFG_*        : cfg_addr register map
//   CTRL_*       : bit positions inside the ctrl register
package video_timing_pkg;

  typedef enum logic [1:0] {
    AX_ACT   = 2'd0,
    AX_FRONT = 2'd1,
    AX_SYNC  = 2'd2,
    AX_BACK  = 2'd3
  } axis_state_t;

  localparam logic [3:0] CFG_H_ACTIVE = 4'd0;
  localparam logic [3:0] CFG_H_FP     = 4'd1;
  localparam logic [3:0] CFG_H_SYNC   = 4'd2;
  localparam logic [3:0] CFG_H_BP     = 4'd3;
  localparam logic [3:0] CFG_V_ACTIVE = 4'd4;
  localparam logic [3:0] CFG_V_FP     = 4'd5;
  localparam logic [3:0] CFG_V_SYNC   = 4'd6;
  localparam logic [3:0] CFG_V_BP     = 4'd7;
  localparam logic [3:0] CFG_CTRL     = 4'd8;
  localparam logic [3:0] CFG_IRQ_LINE = 4'd9;

  localparam int unsigned CTRL_HPOL = 0;
  localparam int unsigned CTRL_VPOL = 1;
  localparam int unsigned CTRL_EN   = 2;

endpackage

// File: rtl/video_timing_gen_if.sv
// Bundle of the generator's config-bus and video-output signals.
//   master : drives pix_en and the config bus, observes video outputs
//   slave  : the generator side
interface video_timing_gen_if #(
  parameter int unsigned BITS_X = 11,
  parameter int unsigned BITS_Y = 11
);
  logic              pix_en;
  logic              cfg_wr;
  logic [3:0]        cfg_addr;
  logic [15:0]       cfg_data;
  logic              hsync;
  logic              vsync;
  logic              blank;
  logic [BITS_X-1:0] x;
  logic [BITS_Y-1:0] y;
  logic              sof;
  logic              sol;
  logic              line_irq;
  logic              cfg_pending;

  modport master (
    output pix_en, cfg_wr, cfg_addr, cfg_data,
    input  hsync, vsync, blank, x, y, sof, sol, line_irq, cfg_pending
  );

  modport slave (
    input  pix_en, cfg_wr, cfg_addr, cfg_data,
    output hsync, vsync, blank, x, y, sof, sol, line_irq, cfg_pending
  );
endinterface

// File: rtl/video_timing_gen_axis.sv
// timing_axis: one timing axis (horizontal or vertical).
// Sequences ACT -> FRONT -> SYNC -> BACK, each phase lasting its length
// (a length of 0 counts as 1) in units of 'step' cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   step       : advance one unit
//   hold       : park at the start of ACT (generator disabled)
//   len_*      : phase lengths
//   state, cnt : current phase and position inside it
//   at_end     : last unit of BACK (wrap point of the axis)
module timing_axis
  import video_timing_pkg::*;
#(
  parameter int unsigned BITS = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            step,
  input  logic            hold,
  input  logic [BITS-1:0] len_act,
  input  logic [BITS-1:0] len_fp,
  input  logic [BITS-1:0] len_sync,
  input  logic [BITS-1:0] len_bp,
  output axis_state_t     state,
  output logic [BITS-1:0] cnt,
  output logic            at_end
);

  logic [BITS-1:0] len_cur;
  logic [BITS-1:0] lim;
  logic            last;

  always_comb begin
    case (state)
      AX_ACT:   len_cur = len_act;
      AX_FRONT: len_cur = len_fp;
      AX_SYNC:  len_cur = len_sync;
      default:  len_cur = len_bp;
    endcase
    lim = (len_cur == '0) ? '0 : len_cur - BITS'(1);
  end

  assign last   = (cnt >= lim);
  assign at_end = (state == AX_BACK) && last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= AX_ACT;
      cnt   <= '0;
    end else if (hold) begin
      state <= AX_ACT;
      cnt   <= '0;
    end else if (step) begin
      if (last) begin
        cnt <= '0;
        case (state)
          AX_ACT:   state <= AX_FRONT;
          AX_FRONT: state <= AX_SYNC;
          AX_SYNC:  state <= AX_BACK;
          default:  state <= AX_ACT;
        endcase
      end else begin
        cnt <= cnt + BITS'(1);
      end
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable raster timing generator.
//   CLK, RSTb        : pixel clock, asynchronous active-low reset
//   pix_en           : pixel clock enable
//   cfg_wr/addr/data : shadow register writes, committed at frame wrap
//   hsync, vsync     : polarity-adjusted syncs
//   blank, x, y      : active-area flag and coordinates
//   sof, sol         : start-of-frame / start-of-line pulses
//   line_irq         : raster-compare pulse
//   cfg_pending      : shadow registers differ from the active set
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned BITS_X   = 11,
  parameter int unsigned BITS_Y   = 11,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic              CLK,
  input  logic              RSTb,
  input  logic              pix_en,
  input  logic              cfg_wr,
  input  logic [3:0]        cfg_addr,
  input  logic [15:0]       cfg_data,
  output logic              hsync,
  output logic              vsync,
  output logic              blank,
  output logic [BITS_X-1:0] x,
  output logic [BITS_Y-1:0] y,
  output logic              sof,
  output logic              sol,
  output logic              line_irq,
  output logic              cfg_pending
);

  localparam int unsigned LN_W = BITS_Y + 2;  // holds any total line count
  localparam logic [BITS_X-1:0] H_DEF [4] =
    '{BITS_X'(H_ACTIVE), BITS_X'(H_FP), BITS_X'(H_SYNC), BITS_X'(H_BP)};
  localparam logic [BITS_Y-1:0] V_DEF [4] =
    '{BITS_Y'(V_ACTIVE), BITS_Y'(V_FP), BITS_Y'(V_SYNC), BITS_Y'(V_BP)};

  logic [BITS_X-1:0] h_len [4], h_shd [4], h_nxt [4];
  logic [BITS_Y-1:0] v_len [4], v_shd [4], v_nxt [4];
  logic [BITS_Y-1:0] irq_line, irq_shd, irq_nxt;
  logic [2:0]        ctrl, ctrl_shd, ctrl_nxt;
  logic              cfg_hit, en_kick, frame_wrap, commit, en;
  logic              unused_cfg_data;

  axis_state_t       h_state, v_state;
  logic [BITS_X-1:0] h_cnt;
  logic [BITS_Y-1:0] v_cnt;
  logic              h_end, v_end, line_start;
  logic [LN_W-1:0]   line_num;

  assign unused_cfg_data = ^cfg_data;
  assign en = ctrl[CTRL_EN];

  timing_axis #(.BITS(BITS_X)) u_h (
    .clk(CLK), .rst_n(RSTb), .step(pix_en), .hold(!en),
    .len_act(h_len[0]), .len_fp(h_len[1]), .len_sync(h_len[2]), .len_bp(h_len[3]),
    .state(h_state), .cnt(h_cnt), .at_end(h_end)
  );

  timing_axis #(.BITS(BITS_Y)) u_v (
    .clk(CLK), .rst_n(RSTb), .step(pix_en && h_end), .hold(!en),
    .len_act(v_len[0]), .len_fp(v_len[1]), .len_sync(v_len[2]), .len_bp(v_len[3]),
    .state(v_state), .cnt(v_cnt), .at_end(v_end)
  );

  // Shadow set including this cycle's write, so a write in the commit
  // cycle is carried into the active set.
  always_comb begin
    h_nxt    = h_shd;
    v_nxt    = v_shd;
    irq_nxt  = irq_shd;
    ctrl_nxt = ctrl_shd;
    cfg_hit  = 1'b0;
    if (cfg_wr) begin
      case (cfg_addr)
        CFG_H_ACTIVE, CFG_H_FP, CFG_H_SYNC, CFG_H_BP: begin
          h_nxt[cfg_addr[1:0]] = BITS_X'(cfg_data);
          cfg_hit = 1'b1;
        end
        CFG_V_ACTIVE, CFG_V_FP, CFG_V_SYNC, CFG_V_BP: begin
          v_nxt[cfg_addr[1:0]] = BITS_Y'(cfg_data);
          cfg_hit = 1'b1;
        end
        CFG_CTRL: begin
          ctrl_nxt = cfg_data[2:0];
          cfg_hit  = 1'b1;
        end
        CFG_IRQ_LINE: begin
          irq_nxt = BITS_Y'(cfg_data);
          cfg_hit = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Re-enabling bypasses the frame-wrap wait: the FSMs are parked at the
  // frame start, so the whole shadow set can be applied at once.
  assign en_kick    = !en && cfg_wr && (cfg_addr == CFG_CTRL) && cfg_data[CTRL_EN];
  assign frame_wrap = pix_en && en && h_end && v_end;
  assign commit     = frame_wrap || en_kick;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      h_len       <= H_DEF;
      h_shd       <= H_DEF;
      v_len       <= V_DEF;
      v_shd       <= V_DEF;
      irq_line    <= '0;
      irq_shd     <= '0;
      ctrl        <= 3'b111;
      ctrl_shd    <= 3'b111;
      cfg_pending <= 1'b0;
    end else begin
      h_shd    <= h_nxt;
      v_shd    <= v_nxt;
      irq_shd  <= irq_nxt;
      ctrl_shd <= ctrl_nxt;
      if (commit) begin
        h_len       <= h_nxt;
        v_len       <= v_nxt;
        irq_line    <= irq_nxt;
        ctrl        <= ctrl_nxt;
        cfg_pending <= 1'b0;
      end else if (cfg_hit) begin
        cfg_pending <= 1'b1;
      end
    end
  end

  // Line number counted from the first active line through blanking.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      line_num <= '0;
    end else if (!en) begin
      line_num <= '0;
    end else if (pix_en && h_end) begin
      line_num <= v_end ? '0 : line_num + LN_W'(1);
    end
  end

  assign line_start = (h_state == AX_ACT) && (h_cnt == '0);

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      blank    <= 1'b1;
      x        <= '0;
      y        <= '0;
      sof      <= 1'b0;
      sol      <= 1'b0;
      line_irq <= 1'b0;
    end else if (!en) begin
      hsync    <= ctrl[CTRL_HPOL];
      vsync    <= ctrl[CTRL_VPOL];
      blank    <= 1'b1;
      x        <= '0;
      y        <= '0;
      sof      <= 1'b0;
      sol      <= 1'b0;
      line_irq <= 1'b0;
    end else if (pix_en) begin
      hsync    <= ctrl[CTRL_HPOL] ^ (h_state == AX_SYNC);
      vsync    <= ctrl[CTRL_VPOL] ^ (v_state == AX_SYNC);
      blank    <= !((h_state == AX_ACT) && (v_state == AX_ACT));
      x        <= (h_state == AX_ACT) ? h_cnt : '0;
      y        <= (v_state == AX_ACT) ? v_cnt : '0;
      sol      <= line_start;
      sof      <= line_start && (v_state == AX_ACT) && (v_cnt == '0);
      line_irq <= line_start && (line_num == LN_W'(irq_line));
    end else begin
      sof      <= 1'b0;
      sol      <= 1'b0;
      line_irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen. The main instance uses a small raster
// (H 10/2/3/5 = 20 clocks per line, V 6/1/2/3 = 12 lines, 240 clocks per
// frame); a second instance keeps the default 640x480 timing for the
// line-level checks.
module tb_video_timing_gen;

  localparam int unsigned BX = 11;
  localparam int unsigned BY = 11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n;

  video_timing_gen_if #(.BITS_X(BX), .BITS_Y(BY)) vif ();

  video_timing_gen #(
    .BITS_X(BX), .BITS_Y(BY),
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(5),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3)
  ) dut (
    .CLK(clk), .RSTb(rst_n), .pix_en(vif.pix_en),
    .cfg_wr(vif.cfg_wr), .cfg_addr(vif.cfg_addr), .cfg_data(vif.cfg_data),
    .hsync(vif.hsync), .vsync(vif.vsync), .blank(vif.blank),
    .x(vif.x), .y(vif.y), .sof(vif.sof), .sol(vif.sol),
    .line_irq(vif.line_irq), .cfg_pending(vif.cfg_pending)
  );

  logic          d_pix_en = 1'b1;
  logic          d_cfg_wr = 1'b0;
  logic [3:0]    d_cfg_addr = 4'd0;
  logic [15:0]   d_cfg_data = 16'd0;
  logic          d_hsync, d_vsync, d_blank, d_sof, d_sol, d_irq, d_pend;
  logic [10:0]   d_x;
  logic [10:0]   d_y;

  video_timing_gen dut_def (
    .CLK(clk), .RSTb(rst_n), .pix_en(d_pix_en),
    .cfg_wr(d_cfg_wr), .cfg_addr(d_cfg_addr), .cfg_data(d_cfg_data),
    .hsync(d_hsync), .vsync(d_vsync), .blank(d_blank),
    .x(d_x), .y(d_y), .sof(d_sof), .sol(d_sol),
    .line_irq(d_irq), .cfg_pending(d_pend)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic probe(input int which);
    case (which)
      0:       return vif.sol;
      1:       return vif.sof;
      2:       return vif.line_irq;
      3:       return !vif.hsync;
      4:       return vif.hsync;
      5:       return !vif.vsync;
      6:       return vif.vsync;
      7:       return d_sol;
      8:       return !d_hsync;
      default: return d_hsync;
    endcase
  endfunction

  // Counts falling edges until the probed condition holds; -1 if it never does.
  task automatic wait_for(input int which, input int limit, output int cycles);
    int   k;
    logic hit;
    k   = 0;
    hit = 1'b0;
    while (!hit && k < limit) begin
      @(negedge clk);
      k++;
      hit = probe(which);
    end
    cycles = hit ? k : -1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
    vif.cfg_addr = a;
    vif.cfg_data = d;
    vif.cfg_wr   = 1'b1;
    @(negedge clk);
    vif.cfg_wr   = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    vif.pix_en   = 1'b0;
    vif.cfg_wr   = 1'b0;
    vif.cfg_addr = 4'd0;
    vif.cfg_data = 16'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_hsync", vif.hsync, 1);
    check("rst_vsync", vif.vsync, 1);
    check("rst_blank", vif.blank, 1);
    check("rst_x", vif.x, 0);
    check("rst_y", vif.y, 0);
    check("rst_pulses", {vif.sof, vif.sol, vif.line_irq}, 0);
    check("rst_pending", vif.cfg_pending, 0);
    check("rst_default_inst",
          {d_hsync, d_vsync, d_blank, d_x, d_y, d_sof, d_sol, d_irq, d_pend},
          {3'b111, 26'd0});

    rst_n      = 1'b1;
    vif.pix_en = 1'b1;
    @(negedge clk);
    check("first_sof", vif.sof, 1);
    check("first_sol", vif.sol, 1);
    check("first_blank", vif.blank, 0);
    check("first_sof_default", d_sof, 1);

    // Default 640x480 line timing
    wait_for(7, 1000, n); check("def_line_period", n, 800);
    wait_for(8, 1000, n); check("def_hsync_start", n, 656);
    wait_for(9, 200, n);  check("def_hsync_width", n, 96);

    // Small raster: line timing
    wait_for(1, 300, n);
    wait_for(0, 100, n); check("line_period", n, 20);
    wait_for(3, 100, n); check("hsync_start", n, 12);
    wait_for(4, 100, n); check("hsync_width", n, 3);

    // Frame timing
    wait_for(1, 300, n);
    check("sof_xy", {vif.x, vif.y}, 0);
    repeat (7) @(negedge clk);
    check("x_mid_line", vif.x, 7);
    wait_for(5, 300, n); check("vsync_start", n, 133);
    check("y_in_vblank", vif.y, 0);
    check("blank_in_vblank", vif.blank, 1);
    wait_for(6, 300, n); check("vsync_width", n, 40);
    wait_for(1, 300, n); check("frame_rest", n, 60);

    // Raster compare
    cfg_write(4'd9, 16'd3);
    check("irq_pending_set", vif.cfg_pending, 1);
    wait_for(1, 300, n); check("irq_commit_sof", n, 239);
    check("irq_pending_clr", vif.cfg_pending, 0);
    wait_for(2, 300, n); check("irq_line3", n, 60);
    check("irq_y", vif.y, 3);
    check("irq_with_sol", vif.sol, 1);
    wait_for(2, 300, n); check("irq_once_per_frame", n, 240);
    cfg_write(4'd9, 16'd9);
    wait_for(2, 400, n); check("irq_blank_line", n, 359);
    check("irq_blank_sol", vif.sol, 1);
    cfg_write(4'd9, 16'd12);
    wait_for(2, 600, n); check("irq_out_of_range", n, -1);

    // pix_en toggling every cycle
    fork
      begin
        repeat (240) @(negedge clk) vif.pix_en = ~vif.pix_en;
      end
      begin
        wait_for(0, 100, n);
        wait_for(0, 100, n); check("toggle_line_period", n, 40);
        @(negedge clk);
        check("toggle_sol_width", vif.sol, 0);
        check("toggle_x_hold", vif.x, 0);
        @(negedge clk);
        check("toggle_x_step", vif.x, 1);
      end
    join
    vif.pix_en = 1'b1;

    // Mid-frame h_active change (0xF805 truncates to 5)
    wait_for(1, 600, n);
    cfg_write(4'd0, 16'hF805);
    check("hact_pending", vif.cfg_pending, 1);
    wait_for(0, 100, n); check("hact_old_rest", n, 19);
    wait_for(0, 100, n); check("hact_old_line", n, 20);
    wait_for(1, 600, n); check("hact_to_wrap", n, 200);
    check("hact_pending_clr", vif.cfg_pending, 0);
    wait_for(0, 100, n); check("hact_new_line", n, 15);
    wait_for(1, 400, n); check("hact_new_frame", n, 165);

    // h_fp=0 written exactly in the commit cycle
    repeat (178) @(negedge clk);
    cfg_write(4'd1, 16'd0);
    check("commit_write_pending", vif.cfg_pending, 0);
    wait_for(1, 10, n);  check("commit_write_sof", n, 1);
    wait_for(3, 100, n); check("hfp0_hsync_start", n, 6);
    wait_for(0, 100, n); check("hfp0_line_rest", n, 8);

    // EN=0 at frame wrap, then immediate re-enable
    cfg_write(4'd8, 16'd3);
    wait_for(1, 300, n); check("disabled_no_sof", n, -1);
    check("disabled_outs", {vif.blank, vif.hsync, vif.vsync, vif.sol}, 4'b1110);
    check("disabled_xy", {vif.x, vif.y}, 0);
    cfg_write(4'd0, 16'd10);
    check("disabled_pending", vif.cfg_pending, 1);
    cfg_write(4'd8, 16'd7);
    check("enable_pending_clr", vif.cfg_pending, 0);
    wait_for(1, 10, n);  check("enable_sof", n, 1);
    wait_for(0, 100, n); check("enable_line", n, 19);

    // Reset mid-frame with pending config
    cfg_write(4'd8, 16'd0);
    cfg_write(4'd0, 16'd7);
    wait_for(0, 100, n); check("pre_rst_line", n, 17);
    check("pre_rst_y", vif.y, 2);
    repeat (3) @(negedge clk);
    check("pre_rst_x", vif.x, 3);
    rst_n = 1'b0;
    #1;
    check("midrst_syncs", {vif.hsync, vif.vsync, vif.blank}, 3'b111);
    check("midrst_xy", {vif.x, vif.y}, 0);
    check("midrst_pending", vif.cfg_pending, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_sof", vif.sof, 1);
    wait_for(0, 100, n); check("post_rst_line", n, 20);
    wait_for(3, 100, n); check("post_rst_hsync", n, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
